// File: rtl/pipes_pkg.sv
// Shared pipeline control types: per-stage flush/stall word, forwarding selects,
// data-memory wait FSM states and a saturating counter helper.
package pipes;

  typedef logic [4:0] creg_addr_t;

  typedef struct packed {
    logic flush;
    logic stall;
  } stage_ctrl_t;

  typedef struct packed {
    stage_ctrl_t fetch;
    stage_ctrl_t decode;
    stage_ctrl_t execute;
    stage_ctrl_t memory;
  } hazard_data_t;

  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT    = 2'b01,
    TIMEOUT = 2'b10
  } dmem_wait_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX operand; the MEM result is newer than WB so it wins.
module hazard_fwd_sel
  import pipes::*;
(
  input  creg_addr_t src,
  input  creg_addr_t m_write_reg,
  input  logic       m_reg_write,
  input  creg_addr_t w_write_reg,
  input  logic       w_reg_write,
  output fwd_sel_t   sel
);

  // Priority select; register $0 is hard-wired and never forwarded.
  always_comb begin
    sel = FWD_RF;
    if (m_reg_write && (m_write_reg != 5'd0) && (m_write_reg == src)) begin
      sel = FWD_MEM;
    end else if (w_reg_write && (w_write_reg != 5'd0) && (w_write_reg == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW forwarding, load-use stall, branch flush and a
// data-memory wait FSM with timeout, plus saturating stall/flush counters.
module hazard_ctrl
  import pipes::*;
#(
  parameter int unsigned DMEM_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  creg_addr_t   d_rs,
  input  creg_addr_t   d_rt,
  input  creg_addr_t   e_rs,
  input  creg_addr_t   e_rt,
  input  creg_addr_t   e_write_reg,
  input  logic         e_reg_write,
  input  logic         e_mem_to_reg,
  input  creg_addr_t   m_write_reg,
  input  logic         m_reg_write,
  input  logic         m_branch_taken,
  input  logic         m_dmem_req,
  input  logic         dmem_ready,
  input  creg_addr_t   w_write_reg,
  input  logic         w_reg_write,
  output hazard_data_t hazard,
  output fwd_sel_t     forwardA,
  output fwd_sel_t     forwardB,
  output logic         dmem_timeout,
  output logic [31:0]  stall_cnt,
  output logic [31:0]  flush_cnt
);

  localparam int unsigned CW = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(DMEM_TIMEOUT - 1);

  dmem_wait_state_t state_r, state_nxt_s;
  logic [CW-1:0]    wait_cnt_r, wait_nxt_s;
  logic             dstall_s, timeout_s, ld_use_s, branch_flush_s;
  hazard_data_t     haz_s;
  fwd_sel_t         fwd_a_s, fwd_b_s;
  logic [31:0]      stall_cnt_r, flush_cnt_r;

  hazard_fwd_sel u_fwd_a (
    .src(e_rs), .m_write_reg(m_write_reg), .m_reg_write(m_reg_write),
    .w_write_reg(w_write_reg), .w_reg_write(w_reg_write), .sel(fwd_a_s)
  );

  hazard_fwd_sel u_fwd_b (
    .src(e_rt), .m_write_reg(m_write_reg), .m_reg_write(m_reg_write),
    .w_write_reg(w_write_reg), .w_reg_write(w_reg_write), .sel(fwd_b_s)
  );

  // Data-memory wait FSM: the stall is capped at DMEM_TIMEOUT cycles, then one drop cycle.
  always_comb begin
    state_nxt_s = state_r;
    wait_nxt_s  = wait_cnt_r;
    dstall_s    = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (m_dmem_req && !dmem_ready) begin
          dstall_s    = 1'b1;
          state_nxt_s = WAIT;
          wait_nxt_s  = CW'(1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (!m_dmem_req || dmem_ready) begin
          state_nxt_s = IDLE;
          wait_nxt_s  = {CW{1'b0}};
        end else begin
          dstall_s    = 1'b1;
          wait_nxt_s  = wait_cnt_r + CW'(1);
          state_nxt_s = (wait_cnt_r >= LAST_WAIT) ? TIMEOUT : WAIT;
        end
      end
      TIMEOUT: begin
        timeout_s   = 1'b1;
        state_nxt_s = IDLE;
        wait_nxt_s  = {CW{1'b0}};
      end
      default: begin
        state_nxt_s = IDLE;
        wait_nxt_s  = {CW{1'b0}};
      end
    endcase
  end

  // Hazard word: memory stall dominates, then branch flush, then load-use bubble.
  always_comb begin
    haz_s          = '0;
    branch_flush_s = 1'b0;
    ld_use_s       = e_reg_write && e_mem_to_reg && (e_write_reg != 5'd0) &&
                     ((e_write_reg == d_rs) || (e_write_reg == d_rt));
    if (dstall_s) begin
      haz_s.fetch.stall   = 1'b1;
      haz_s.decode.stall  = 1'b1;
      haz_s.execute.stall = 1'b1;
      haz_s.memory.flush  = 1'b1;
    end else begin
      haz_s.memory.flush = timeout_s;
      if (m_branch_taken) begin
        haz_s.fetch.flush   = 1'b1;
        haz_s.decode.flush  = 1'b1;
        haz_s.execute.flush = 1'b1;
        branch_flush_s      = 1'b1;
      end else if (ld_use_s) begin
        haz_s.fetch.stall  = 1'b1;
        haz_s.decode.flush = 1'b1;
      end else begin
        branch_flush_s = 1'b0;
      end
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      wait_cnt_r <= {CW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_nxt_s;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (haz_s.fetch.stall) stall_cnt_r <= sat_inc32(stall_cnt_r);
      if (branch_flush_s)    flush_cnt_r <= sat_inc32(flush_cnt_r);
    end
  end

  assign hazard       = reset ? haz_s     : '0;
  assign forwardA     = reset ? fwd_a_s   : FWD_RF;
  assign forwardB     = reset ? fwd_b_s   : FWD_RF;
  assign dmem_timeout = reset ? timeout_s : 1'b0;
  assign stall_cnt    = stall_cnt_r;
  assign flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (DMEM_TIMEOUT=4) with hand-computed hazard words.
module tb_hazard_ctrl;

  // hazard bits: 7 f.flush 6 f.stall 5 d.flush 4 d.stall 3 e.flush 2 e.stall 1 m.flush 0 m.stall
  localparam logic [7:0] H_NONE = 8'b0000_0000;
  localparam logic [7:0] H_LU   = 8'b0110_0000;
  localparam logic [7:0] H_BR   = 8'b1010_1000;
  localparam logic [7:0] H_DS   = 8'b0101_0110;
  localparam logic [7:0] H_TO   = 8'b0000_0010;

  logic        clk, reset;
  logic [4:0]  d_rs, d_rt, e_rs, e_rt, e_write_reg, m_write_reg, w_write_reg;
  logic        e_reg_write, e_mem_to_reg, m_reg_write, m_branch_taken;
  logic        m_dmem_req, dmem_ready, w_reg_write;
  logic [7:0]  hazard;
  logic [1:0]  forwardA, forwardB;
  logic        dmem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.DMEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .e_rs(e_rs), .e_rt(e_rt),
    .e_write_reg(e_write_reg), .e_reg_write(e_reg_write), .e_mem_to_reg(e_mem_to_reg),
    .m_write_reg(m_write_reg), .m_reg_write(m_reg_write), .m_branch_taken(m_branch_taken),
    .m_dmem_req(m_dmem_req), .dmem_ready(dmem_ready),
    .w_write_reg(w_write_reg), .w_reg_write(w_reg_write),
    .hazard(hazard), .forwardA(forwardA), .forwardB(forwardB),
    .dmem_timeout(dmem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    d_rs = 5'd0; d_rt = 5'd0; e_rs = 5'd0; e_rt = 5'd0;
    e_write_reg = 5'd0; e_reg_write = 1'b0; e_mem_to_reg = 1'b0;
    m_write_reg = 5'd0; m_reg_write = 1'b0; m_branch_taken = 1'b0;
    m_dmem_req = 1'b0; dmem_ready = 1'b0;
    w_write_reg = 5'd0; w_reg_write = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    m_write_reg = 5'd3; m_reg_write = 1'b1; e_rs = 5'd3; m_dmem_req = 1'b1;
    #12;
    chk("rst_hazard", {24'd0, hazard}, {24'd0, H_NONE});
    chk("rst_fwdA", {30'd0, forwardA}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    clear_inputs();
    reset = 1'b1;
    tick();

    // Forwarding
    m_write_reg = 5'd3; m_reg_write = 1'b1; e_rs = 5'd3; #1;
    chk("fwd_mem", {30'd0, forwardA}, 32'd2);
    w_write_reg = 5'd3; w_reg_write = 1'b1; e_rt = 5'd3; #1;
    chk("fwd_mem_beats_wb", {30'd0, forwardA}, 32'd2);
    m_reg_write = 1'b0; #1;
    chk("fwd_wb", {30'd0, forwardB}, 32'd1);
    m_write_reg = 5'd0; m_reg_write = 1'b1; w_write_reg = 5'd0;
    e_rs = 5'd0; e_rt = 5'd0; #1;
    chk("fwd_zero_A", {30'd0, forwardA}, 32'd0);
    chk("fwd_zero_B", {30'd0, forwardB}, 32'd0);
    clear_inputs(); #1;

    // Load-use
    e_reg_write = 1'b1; e_mem_to_reg = 1'b1; e_write_reg = 5'd5; d_rt = 5'd5; #1;
    chk("lu_hazard", {24'd0, hazard}, {24'd0, H_LU});
    chk("lu_cnt_before", stall_cnt, 32'd0);
    tick();
    clear_inputs(); #1;
    chk("lu_cleared", {24'd0, hazard}, {24'd0, H_NONE});
    chk("lu_cnt_after", stall_cnt, 32'd1);
    e_reg_write = 1'b1; e_mem_to_reg = 1'b1; e_write_reg = 5'd0; #1;
    chk("lu_r0_none", {24'd0, hazard}, {24'd0, H_NONE});

    // Branch overrides load-use
    e_write_reg = 5'd5; d_rs = 5'd5; m_branch_taken = 1'b1; #1;
    chk("br_lu_hazard", {24'd0, hazard}, {24'd0, H_BR});
    tick();
    clear_inputs(); #1;
    chk("br_flush_cnt", flush_cnt, 32'd1);
    chk("br_stall_cnt", stall_cnt, 32'd1);

    // Dmem wait, branch held until stall clears
    m_dmem_req = 1'b1; #1;
    chk("ds_c1", {24'd0, hazard}, {24'd0, H_DS});
    tick();
    m_branch_taken = 1'b1; #1;
    chk("ds_c2_br", {24'd0, hazard}, {24'd0, H_DS});
    tick(); #1;
    chk("ds_c3_br", {24'd0, hazard}, {24'd0, H_DS});
    chk("ds_flush_held", flush_cnt, 32'd1);
    tick();
    dmem_ready = 1'b1; #1;
    chk("ds_ready_br", {24'd0, hazard}, {24'd0, H_BR});
    tick();
    clear_inputs(); #1;
    chk("ds_stall_cnt", stall_cnt, 32'd4);
    chk("ds_flush_cnt", flush_cnt, 32'd2);
    chk("ds_idle", {24'd0, hazard}, {24'd0, H_NONE});

    // Timeout
    m_dmem_req = 1'b1; #1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("to_ds_c%0d", i), {24'd0, hazard}, {24'd0, H_DS});
      chk($sformatf("to_pulse_c%0d", i), {31'd0, dmem_timeout}, 32'd0);
      tick();
    end
    chk("to_hazard", {24'd0, hazard}, {24'd0, H_TO});
    chk("to_pulse", {31'd0, dmem_timeout}, 32'd1);
    tick();
    chk("to_back_idle", {24'd0, hazard}, {24'd0, H_DS});
    chk("to_pulse_gone", {31'd0, dmem_timeout}, 32'd0);
    tick();
    m_dmem_req = 1'b0; #1;
    chk("req_drop", {24'd0, hazard}, {24'd0, H_NONE});
    tick();
    chk("to_stall_cnt", stall_cnt, 32'd9);

    // Async reset mid-WAIT
    m_dmem_req = 1'b1;
    tick();
    tick();
    reset = 1'b0; #1;
    chk("ar_hazard", {24'd0, hazard}, {24'd0, H_NONE});
    chk("ar_pulse", {31'd0, dmem_timeout}, 32'd0);
    chk("ar_stall_cnt", stall_cnt, 32'd0);
    chk("ar_flush_cnt", flush_cnt, 32'd0);
    #2;
    reset = 1'b1; #1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ar_ds_c%0d", i), {24'd0, hazard}, {24'd0, H_DS});
      tick();
    end
    chk("ar_to_hazard", {24'd0, hazard}, {24'd0, H_TO});
    chk("ar_to_pulse", {31'd0, dmem_timeout}, 32'd1);
    chk("ar_stall_recount", stall_cnt, 32'd4);
    clear_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
